multicore_data_mem: RTL and testbench

- Banked data memory plus run sequencer that sits directly downstream of the multicore processor array.
- One bank per core, all banks share a single address and a single write enable, and each bank has its own data lane.
- A host port loads operands before a run and reads results back afterwards.
- A small FSM hands ownership to the cores, pulses their start, waits for done, and counts run cycles.

---
 rtl/multicore_data_mem_pkg.sv | 15 +
 rtl/multicore_data_mem_data_bank.sv | 26 ++
 rtl/multicore_data_mem.sv | 169 ++++++++++++++++
 tb/tb_multicore_data_mem.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multicore_data_mem_pkg.sv
// rtl/multicore_data_mem_pkg.sv - shared state encoding and parameter checks for the banked data memory
package multicore_data_mem_pkg;

    typedef enum logic [1:0] {
        ST_HOST   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // The host bank select must be able to name every core's bank.
    function automatic bit bank_sel_fits(input int bank_sel, input int core_count);
        return (64'd1 << bank_sel) >= 64'(core_count);
    endfunction

endpackage

// File: rtl/multicore_data_mem_data_bank.sv
// rtl/multicore_data_mem_data_bank.sv - single-port synchronous RAM with one-cycle registered read
module multicore_data_mem_data_bank #(
    parameter int WIDTH = 12,
    parameter int ADDR  = 12
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR];
    logic [WIDTH-1:0] rdata_q;

    // Read and write on the same edge: the read sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multicore_data_mem.sv
// rtl/multicore_data_mem.sv - banked core data memory with host load/readback port and run sequencer
module multicore_data_mem
    import multicore_data_mem_pkg::*;
#(
    parameter int CORE_COUNT = 4,
    parameter int MEM_WIDTH  = 12,
    parameter int MEM_ADDR   = 12,
    parameter int BANK_SEL   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [MEM_ADDR-1:0]             MemAddr,
    input  logic                            DataMemoryWriteEnable,
    input  logic [MEM_WIDTH*CORE_COUNT-1:0] ProcessorDataOut,
    output logic [MEM_WIDTH*CORE_COUNT-1:0] ProcessorDataIn,
    input  logic                            done,
    output logic                            start,
    input  logic                            host_go,
    input  logic                            host_we,
    input  logic                            host_re,
    input  logic [BANK_SEL-1:0]             host_bank,
    input  logic [MEM_ADDR-1:0]             host_addr,
    input  logic [MEM_WIDTH-1:0]            host_wdata,
    output logic [MEM_WIDTH-1:0]            host_rdata,
    output logic                            host_rvalid,
    output logic                            host_err,
    output logic                            busy,
    output logic                            finished,
    output logic [CNT_WIDTH-1:0]            run_cycles
);

    localparam bit BankSelFits = bank_sel_fits(BANK_SEL, CORE_COUNT);

    if (!BankSelFits) begin : g_bank_sel_check
        $error("BANK_SEL too narrow to address every bank");
    end

    state_e state_q, state_d;

    logic                            bank_ok;
    logic                            host_wr;
    logic                            host_rd;
    logic                            host_err_d;
    logic                            host_rvalid_q;
    logic                            host_err_q;
    logic [BANK_SEL-1:0]             host_bank_q;
    logic                            finished_q, finished_d;
    logic [CNT_WIDTH-1:0]            run_cycles_q, run_cycles_d;
    logic                            core_rd_q;
    logic [MEM_WIDTH*CORE_COUNT-1:0] core_hold_q;
    logic [MEM_WIDTH*CORE_COUNT-1:0] bank_rdata;
    logic [MEM_ADDR-1:0]             bank_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOST:   if (host_go) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN:    if (done) state_d = ST_HOST;
            default:   state_d = ST_HOST;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        case (state_q)
            ST_LAUNCH: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            ST_RUN:  busy = 1'b1;
            default: ;
        endcase
    end

    assign bank_ok = int'(host_bank) < CORE_COUNT;
    assign host_wr = !busy && host_we && bank_ok;
    assign host_rd = !busy && host_re && !host_we && bank_ok;

    always_comb begin
        host_err_d = 1'b0;
        if (busy) begin
            host_err_d = host_we || host_re || host_go;
        end else begin
            host_err_d = (host_we && host_re) || ((host_we || host_re) && !bank_ok);
        end
    end

    always_comb begin
        finished_d   = finished_q;
        run_cycles_d = run_cycles_q;
        if (state_q == ST_HOST && host_go) begin
            finished_d   = 1'b0;
            run_cycles_d = '0;
        end else if (state_q == ST_RUN) begin
            if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
            if (done) finished_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
            host_err_q    <= 1'b0;
            host_bank_q   <= '0;
            finished_q    <= 1'b0;
            run_cycles_q  <= '0;
            core_rd_q     <= 1'b0;
            core_hold_q   <= '0;
        end else begin
            host_rvalid_q <= host_rd;
            host_err_q    <= host_err_d;
            if (host_rd) host_bank_q <= host_bank;
            finished_q    <= finished_d;
            run_cycles_q  <= run_cycles_d;
            core_rd_q     <= busy;
            if (core_rd_q) core_hold_q <= bank_rdata;
        end
    end

    assign bank_addr = busy ? MemAddr : host_addr;

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_bank
        logic                 bank_we;
        logic [MEM_WIDTH-1:0] bank_wdata;

        assign bank_we    = busy ? DataMemoryWriteEnable : (host_wr && host_bank == BANK_SEL'(i));
        assign bank_wdata = busy ? ProcessorDataOut[i*MEM_WIDTH +: MEM_WIDTH] : host_wdata;

        multicore_data_mem_data_bank #(
            .WIDTH (MEM_WIDTH),
            .ADDR  (MEM_ADDR)
        ) u_bank (
            .clk_i   (clock),
            .we_i    (bank_we),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[i*MEM_WIDTH +: MEM_WIDTH])
        );
    end

    // Host reads also move the bank output, so cores see a held copy outside a run.
    assign ProcessorDataIn = core_rd_q ? bank_rdata : core_hold_q;

    always_comb begin
        host_rdata = '0;
        if (host_rvalid_q) begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (host_bank_q == BANK_SEL'(i)) host_rdata = bank_rdata[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_err    = host_err_q;
    assign finished    = finished_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_multicore_data_mem.sv
// tb/tb_multicore_data_mem.sv - directed self-checking bench for multicore_data_mem
module tb_multicore_data_mem;

    localparam int CC = 4;
    localparam int MW = 12;
    localparam int MA = 12;
    localparam int BS = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [MA-1:0]    MemAddr = '0;
    logic             DataMemoryWriteEnable = 1'b0;
    logic [MW*CC-1:0] ProcessorDataOut = '0;
    logic             done = 1'b0;
    logic             host_go = 1'b0;
    logic             host_we = 1'b0;
    logic             host_re = 1'b0;
    logic [BS-1:0]    host_bank = '0;
    logic [MA-1:0]    host_addr = '0;
    logic [MW-1:0]    host_wdata = '0;

    logic [MW*CC-1:0] pdin, pdin_s;
    logic             start, start_s;
    logic [MW-1:0]    host_rdata, host_rdata_s;
    logic             host_rvalid, host_rvalid_s;
    logic             host_err, host_err_s;
    logic             busy, busy_s;
    logic             finished, finished_s;
    logic [15:0]      run_cycles;
    logic [3:0]       run_cycles_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    multicore_data_mem #(
        .CORE_COUNT(CC), .MEM_WIDTH(MW), .MEM_ADDR(MA), .BANK_SEL(BS), .CNT_WIDTH(16)
    ) u_dut (
        .clock(clock), .reset(reset), .MemAddr(MemAddr),
        .DataMemoryWriteEnable(DataMemoryWriteEnable), .ProcessorDataOut(ProcessorDataOut),
        .ProcessorDataIn(pdin), .done(done), .start(start), .host_go(host_go),
        .host_we(host_we), .host_re(host_re), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_err(host_err), .busy(busy), .finished(finished), .run_cycles(run_cycles)
    );

    multicore_data_mem #(
        .CORE_COUNT(CC), .MEM_WIDTH(MW), .MEM_ADDR(MA), .BANK_SEL(BS), .CNT_WIDTH(4)
    ) u_sat (
        .clock(clock), .reset(reset), .MemAddr(MemAddr),
        .DataMemoryWriteEnable(DataMemoryWriteEnable), .ProcessorDataOut(ProcessorDataOut),
        .ProcessorDataIn(pdin_s), .done(done), .start(start_s), .host_go(host_go),
        .host_we(host_we), .host_re(host_re), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata_s), .host_rvalid(host_rvalid_s),
        .host_err(host_err_s), .busy(busy_s), .finished(finished_s), .run_cycles(run_cycles_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [BS-1:0] bank, input logic [MA-1:0] addr, input logic [MW-1:0] data);
        host_we    = 1'b1;
        host_bank  = bank;
        host_addr  = addr;
        host_wdata = data;
        step();
        host_we    = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [BS-1:0] bank, input logic [MA-1:0] addr, input logic [MW-1:0] exp);
        host_re   = 1'b1;
        host_bank = bank;
        host_addr = addr;
        step();
        host_re   = 1'b0;
        check({tag, "_rvalid"}, 64'(host_rvalid), 64'd1);
        check({tag, "_rdata"}, 64'(host_rdata), 64'(exp));
        step();
        check({tag, "_rvalid_drop"}, 64'(host_rvalid), 64'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_start", 64'(start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finished", 64'(finished), 64'd0);
        check("rst_run_cycles", 64'(run_cycles), 64'd0);
        check("rst_rvalid", 64'(host_rvalid), 64'd0);
        check("rst_err", 64'(host_err), 64'd0);
        check("rst_pdin", 64'(pdin), 64'd0);
        reset = 1'b0;
        step();

        host_write(3'd0, 12'h010, 12'h100);
        host_write(3'd1, 12'h010, 12'h101);
        host_write(3'd3, 12'h010, 12'h103);
        host_write(3'd2, 12'h010, 12'hABC);
        for (int b = 0; b < CC; b++) host_write(3'(b), 12'h005, 12'h000);
        host_read("rd_b2", 3'd2, 12'h010, 12'hABC);
        host_read("rd_b0", 3'd0, 12'h010, 12'h100);
        host_read("rd_b1", 3'd1, 12'h010, 12'h101);
        host_read("rd_b3", 3'd3, 12'h010, 12'h103);

        // Write and read together: write lands, read is dropped with an error.
        host_we = 1'b1; host_re = 1'b1; host_bank = 3'd0; host_addr = 12'h020; host_wdata = 12'h055;
        step();
        host_we = 1'b0; host_re = 1'b0;
        check("wr_rd_err", 64'(host_err), 64'd1);
        check("wr_rd_no_rvalid", 64'(host_rvalid), 64'd0);
        step();
        check("wr_rd_err_pulse", 64'(host_err), 64'd0);
        host_read("wr_rd_data", 3'd0, 12'h020, 12'h055);

        host_re = 1'b1; host_bank = 3'd5; host_addr = 12'h010;
        step();
        host_re = 1'b0;
        check("bad_bank_err", 64'(host_err), 64'd1);
        check("bad_bank_no_rvalid", 64'(host_rvalid), 64'd0);

        // Run 1: ten RUN cycles including the done cycle.
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        check("launch_start", 64'(start), 64'd1);
        check("launch_busy", 64'(busy), 64'd1);
        step();
        check("run_start_low", 64'(start), 64'd0);
        check("run_busy", 64'(busy), 64'd1);
        MemAddr = 12'h005; DataMemoryWriteEnable = 1'b1;
        ProcessorDataOut = 48'h444_333_222_111;
        step();
        DataMemoryWriteEnable = 1'b0;
        step();
        check("core_bcast_read", 64'(pdin), 64'h444_333_222_111);
        host_write(3'd1, 12'h010, 12'hFFF);
        check("contention_err", 64'(host_err), 64'd1);
        repeat (6) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("run1_finished", 64'(finished), 64'd1);
        check("run1_busy", 64'(busy), 64'd0);
        check("run1_cycles", 64'(run_cycles), 64'd10);
        check("run1_cycles_w4", 64'(run_cycles_s), 64'd10);
        host_read("contention_mem", 3'd1, 12'h010, 12'h101);
        check("pdin_hold", 64'(pdin), 64'h444_333_222_111);
        host_read("core_b0", 3'd0, 12'h005, 12'h111);
        host_read("core_b1", 3'd1, 12'h005, 12'h222);
        host_read("core_b2", 3'd2, 12'h005, 12'h333);
        host_read("core_b3", 3'd3, 12'h005, 12'h444);

        // Run 2: done in LAUNCH is ignored, then 21 RUN cycles saturate the 4-bit counter.
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        check("go_clears_finished", 64'(finished), 64'd0);
        check("go_clears_cycles", 64'(run_cycles), 64'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        check("launch_done_ignored", 64'(busy), 64'd1);
        repeat (20) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("run2_cycles", 64'(run_cycles), 64'd21);
        check("run2_cycles_sat", 64'(run_cycles_s), 64'hF);
        check("run2_finished_w4", 64'(finished_s), 64'd1);

        // Reset in the middle of a run.
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_start", 64'(start), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_finished", 64'(finished), 64'd0);
        check("mid_rst_cycles", 64'(run_cycles), 64'd0);
        step();
        reset = 1'b0;
        step();
        host_read("mid_rst_mem", 3'd2, 12'h010, 12'hABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
